mc_mips_controller: RTL and testbench
=====================================

// Module: mc_mips_controller
// PURPOSE
//  Multicycle successor to the single-cycle MIPS control unit: a Moore FSM that drives the datapath through
//  FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, waits on a ready handshake from memory and counts retired instructions.
//  Sits between the instruction register (IR, loaded via IRWrite) and the shared ALU, register file and memory.
// PARAMETERS
//  MEM_TIMEOUT   16  max wait cycles for MemReady in any memory state before FAULT (1..255)
//  CNT_W         32  width of retired-instruction counter RetireCnt
// PORTS
//  Clk           in   1      clock, all state on rising edge
//  Reset_n       in   1      asynchronous, active-low reset
//  Instruction   in   32     IR contents; stable from DECODE until the next FETCH
//  MemReady      in   1      memory completed current read/write this cycle
//  Zero          in   1      ALU zero flag
//  AluLsb        in   1      ALUResult[0] (SLT/GT outcome)
//  IRWrite       out  1      load IR from memory data
//  IorD          out  1      0=PC addresses memory, 1=ALU result
//  MemRead       out  1      memory read request (held until MemReady)
//  MemWrite      out  1      memory write request (held until MemReady)
//  PCWrite       out  1      update PC from PCSource
//  PCSource      out  2      0=PC+4, 1=branch target, 2=jump target, 3=rs (JR)
//  RegWrite      out  1      register file write enable
//  RegDst        out  2      0=rt, 1=rd, 2=r31
//  RegDataSel    out  2      0=ALU result, 1=memory data, 2=PC+4 (link)
//  ALUASrc       out  1      0=rs, 1=rt
//  ALUBSrc       out  2      0=rt, 1=ext imm, 2=0, 3=1
//  ALUControl    out  4      0 AND,1 OR,2 ADD,3 NOR,6 SUB,7 SLT,10 SLL,11 GT
//  ExtendSign    out  1      1 for ADDI/LW/SW/branches, else 0
//  State         out  4      current state encoding; Busy = (State!=FETCH)
//  Fault         out  1      sticky; set on memory timeout (and illegal op, see CONFIGURATION)
//  RetireCnt     out  CNT_W  instructions completed, wraps modulo 2^CNT_W
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC_R=2 EXEC_I=3 MEM_ADDR=4 MEM_RD=5 MEM_WB=6 MEM_WR=7 BRANCH=8 JUMP=9 WB=10 FAULT=15.
//  Reset (async, Reset_n=0): State=FETCH, wait counter=0, Fault=0, RetireCnt=0; every output decodes to 0 except State=0.
//  Outputs are Moore: combinational from State and Instruction; all other control outputs 0.
//  FETCH: IorD=0, MemRead=1. On MemReady: IRWrite=1, PCWrite=1, PCSource=0, -> DECODE. Else stay.
//  DECODE: Instruction==0 (NOP) -> FETCH, retired. R-type ADD/ADDU/SUB/AND/OR/NOR/SLT/SLL -> EXEC_R; JR -> JUMP;
//   ADDI/ADDIU/ANDI/ORI -> EXEC_I; LW/SW -> MEM_ADDR; BEQ/BNE/BLTZ/BGEZ/BGTZ -> BRANCH; J/JAL -> JUMP.
//  EXEC_R/EXEC_I: ALU op per funct/opcode (SLL: ALUASrc=1, ALUBSrc=1); -> WB.
//  WB: RegWrite=1, RegDst=1 (R) or 0 (I), RegDataSel=0; -> FETCH, retired. ALU controls held from EXEC.
//  MEM_ADDR: ALUControl=2, ALUBSrc=1, ExtendSign=1; -> MEM_RD (LW) or MEM_WR (SW).
//  MEM_RD: IorD=1, MemRead=1; MemReady -> MEM_WB. MEM_WB: RegWrite=1, RegDst=0, RegDataSel=1 -> FETCH, retired.
//  MEM_WR: IorD=1, MemWrite=1; MemReady -> FETCH, retired.
//  BRANCH: ALUControl=6 (BEQ/BNE, ALUBSrc=0), 7 (BLTZ/BGEZ, ALUBSrc=2), 11 (BGTZ, ALUBSrc=2);
//   PCWrite=1,PCSource=1 iff BEQ&Zero | BNE&~Zero | (BLTZ|BGTZ)&AluLsb | BGEZ&~AluLsb; -> FETCH, retired.
//  JUMP: PCWrite=1, PCSource=2 (J/JAL) or 3 (JR); JAL also RegWrite=1, RegDst=2, RegDataSel=2; -> FETCH, retired.
//  Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR, +1 each cycle MemReady=0 there; reaching MEM_TIMEOUT -> FAULT,
//   Fault=1 same edge. MemReady in the cycle counter hits MEM_TIMEOUT-1 is accepted (ready wins over timeout).
//  FAULT: all control outputs 0; exit only via reset. RetireCnt frozen.
//  "Retired" = RetireCnt+1 on the edge leaving for FETCH; all-ones wraps to 0, Fault unaffected.
//  Reset asserted mid-memory-access drops MemRead/MemWrite asynchronously; no partial writeback.
// CONFIGURATION
//  MC_CTRL_ILLEGAL_TRAP_EN defined: unsupported opcode/funct in DECODE -> FAULT, Fault=1, not retired.
//  Not defined: unsupported encodings behave as NOP (DECODE -> FETCH, retired, no writes).
// TESTING
//  ADD $3,$1,$2 with MemReady=1 in FETCH -> FETCH,DECODE,EXEC_R,WB (4 cyc), RegWrite=1 RegDst=1 in WB, RetireCnt=1.
//  LW with MemReady low 3 cycles in MEM_RD -> MemRead/IorD held 3 cyc, MEM_WB RegDataSel=1, total 8 cycles.
//  BEQ Zero=1 -> PCWrite=1 PCSource=1 in BRANCH; BNE Zero=1 -> PCWrite=0; BGEZ AluLsb=0 -> taken.
//  JAL -> JUMP with RegDst=2 RegDataSel=2 RegWrite=1 PCSource=2; JR -> PCSource=3, RegWrite=0.
//  MemReady held 0 in FETCH for MEM_TIMEOUT=16 cycles -> FAULT, Fault=1 sticky; Reset_n low -> FETCH, Fault=0.
//  Opcode 6'h3F: with MC_CTRL_ILLEGAL_TRAP_EN -> FAULT; without -> FETCH, RetireCnt+1; preset CNT_W=4 at 15 wraps to 0.

Source files
------------

// File: rtl/mc_mips_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback
// with a memory-ready timeout and a retired-instruction counter. Optional macro: MC_CTRL_ILLEGAL_TRAP_EN.
module mc_mips_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [31:0]      Instruction,
  input  logic             MemReady,
  input  logic             Zero,
  input  logic             AluLsb,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSource,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       RegDataSel,
  output logic             ALUASrc,
  output logic [1:0]       ALUBSrc,
  output logic [3:0]       ALUControl,
  output logic             ExtendSign,
  output logic [3:0]       State,
  output logic             Fault,
  output logic [CNT_W-1:0] RetireCnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_WB       = 4'd10,
    S_FAULT    = 4'd15
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_R, C_JR, C_I, C_LW, C_SW,
    C_BEQ, C_BNE, C_BLTZ, C_BGEZ, C_BGTZ, C_J, C_JAL, C_ILL
  } cls_t;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_NOR = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd10;
  localparam logic [3:0] ALU_GT  = 4'd11;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state, next_state;
  cls_t             cls;
  logic [3:0]       alu_op;
  logic             sll_op;
  logic             sext_op;
  logic [7:0]       wait_cnt;
  logic             waiting;
  logic             timeout;
  logic             retire;
  logic             br_taken;
  logic [CNT_W-1:0] retire_cnt;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       rt;

  assign opcode = Instruction[31:26];
  assign funct  = Instruction[5:0];
  assign rt     = Instruction[20:16];

  // Instruction class plus the ALU setup used by EXEC and held through WB.
  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cls     = C_ILL;
    alu_op  = ALU_AND;
    sll_op  = 1'b0;
    sext_op = 1'b0;
    if (Instruction == 32'd0) begin
      cls = C_NOP;
    end else begin
      case (opcode)
        6'h00: begin
          cls = C_R;
          case (funct)
            6'h20, 6'h21: alu_op = ALU_ADD;
            6'h22:        alu_op = ALU_SUB;
            6'h24:        alu_op = ALU_AND;
            6'h25:        alu_op = ALU_OR;
            6'h27:        alu_op = ALU_NOR;
            6'h2A:        alu_op = ALU_SLT;
            6'h00: begin
              alu_op = ALU_SLL;
              sll_op = 1'b1;
            end
            6'h08:        cls = C_JR;
            default:      cls = C_ILL;
          endcase
        end
        6'h01: begin
          sext_op = 1'b1;
          if (rt == 5'd0)      cls = C_BLTZ;
          else if (rt == 5'd1) cls = C_BGEZ;
          else                 cls = C_ILL;
        end
        6'h02: cls = C_J;
        6'h03: cls = C_JAL;
        6'h04: begin cls = C_BEQ;  sext_op = 1'b1; end
        6'h05: begin cls = C_BNE;  sext_op = 1'b1; end
        6'h07: begin cls = C_BGTZ; sext_op = 1'b1; end
        6'h08: begin cls = C_I; alu_op = ALU_ADD; sext_op = 1'b1; end
        6'h09: begin cls = C_I; alu_op = ALU_ADD; end
        6'h0C: begin cls = C_I; alu_op = ALU_AND; end
        6'h0D: begin cls = C_I; alu_op = ALU_OR;  end
        6'h23: begin cls = C_LW; sext_op = 1'b1; end
        6'h2B: begin cls = C_SW; sext_op = 1'b1; end
        default: cls = C_ILL;
      endcase
    end
  end

  assign br_taken = (cls == C_BEQ && Zero) || (cls == C_BNE && !Zero) ||
                    ((cls == C_BLTZ || cls == C_BGTZ) && AluLsb) ||
                    (cls == C_BGEZ && !AluLsb);

  assign waiting = (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR) && !MemReady;
  assign timeout = (wait_cnt == WAIT_LAST);

  always_comb begin
    next_state = state;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    PCWrite    = 1'b0;
    PCSource   = 2'd0;
    RegWrite   = 1'b0;
    RegDst     = 2'd0;
    RegDataSel = 2'd0;
    ALUASrc    = 1'b0;
    ALUBSrc    = 2'd0;
    ALUControl = ALU_AND;
    ExtendSign = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_DECODE;
        end else if (timeout) begin
          next_state = S_FAULT;
        end
      end
      S_DECODE: begin
        case (cls)
          C_NOP:                        next_state = S_FETCH;
          C_R:                          next_state = S_EXEC_R;
          C_I:                          next_state = S_EXEC_I;
          C_JR, C_J, C_JAL:             next_state = S_JUMP;
          C_LW, C_SW:                   next_state = S_MEM_ADDR;
          C_BEQ, C_BNE, C_BLTZ,
          C_BGEZ, C_BGTZ:               next_state = S_BRANCH;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            next_state = S_FAULT;
`else
            next_state = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_WB: begin
        ALUControl = alu_op;
        ALUASrc    = sll_op;
        ALUBSrc    = (cls == C_I || sll_op) ? 2'd1 : 2'd0;
        ExtendSign = sext_op;
        if (state == S_WB) begin
          RegWrite   = 1'b1;
          RegDst     = (cls == C_R) ? 2'd1 : 2'd0;
          next_state = S_FETCH;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM_ADDR: begin
        ALUControl = ALU_ADD;
        ALUBSrc    = 2'd1;
        ExtendSign = 1'b1;
        next_state = (cls == C_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (MemReady)     next_state = S_MEM_WB;
        else if (timeout) next_state = S_FAULT;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        RegDataSel = 2'd1;
        next_state = S_FETCH;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MemReady)     next_state = S_FETCH;
        else if (timeout) next_state = S_FAULT;
      end
      S_BRANCH: begin
        ExtendSign = 1'b1;
        case (cls)
          C_BEQ, C_BNE:   begin ALUControl = ALU_SUB; ALUBSrc = 2'd0; end
          C_BLTZ, C_BGEZ: begin ALUControl = ALU_SLT; ALUBSrc = 2'd2; end
          default:        begin ALUControl = ALU_GT;  ALUBSrc = 2'd2; end
        endcase
        if (br_taken) begin
          PCWrite  = 1'b1;
          PCSource = 2'd1;
        end
        next_state = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = (cls == C_JR) ? 2'd3 : 2'd2;
        if (cls == C_JAL) begin
          RegWrite   = 1'b1;
          RegDst     = 2'd2;
          RegDataSel = 2'd2;
        end
        next_state = S_FETCH;
      end
      default: next_state = S_FAULT;
    endcase
    // Reset must kill an in-flight memory request immediately, not at the next edge.
    if (!Reset_n) begin
      {IRWrite, IorD, MemRead, MemWrite, PCWrite, PCSource, RegWrite,
       RegDst, RegDataSel, ALUASrc, ALUBSrc, ALUControl, ExtendSign} = '0;
    end
  end

  assign retire = (state != S_FETCH) && (next_state == S_FETCH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      retire_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= waiting ? wait_cnt + 8'd1 : 8'd0;
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  assign State     = state;
  assign Fault     = (state == S_FAULT);
  assign RetireCnt = retire_cnt;

endmodule

// File: tb/tb_mc_mips_controller.sv
// Directed bench for mc_mips_controller: instruction flows, branch outcomes, memory wait/timeout,
// async reset and a 4-bit retire counter wrap on a second instance.
module tb_mc_mips_controller;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220004;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_BNE  = 32'h14220003;
  localparam logic [31:0] I_BGEZ = 32'h04210003;
  localparam logic [31:0] I_BGTZ = 32'h1C200003;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_ADDI = 32'h20220005;
  localparam logic [31:0] I_SLL  = 32'h00021900;
  localparam logic [31:0] I_ILL  = 32'hFC000000;

  logic        Clk, Reset_n, MemReady, Zero, AluLsb;
  logic [31:0] Instruction;
  logic        IRWrite, IorD, MemRead, MemWrite, PCWrite, RegWrite, ALUASrc, ExtendSign, Fault;
  logic [1:0]  PCSource, RegDst, RegDataSel, ALUBSrc;
  logic [3:0]  ALUControl, State;
  logic [31:0] RetireCnt;

  logic        s_irw, s_iord, s_mrd, s_mwr, s_pcw, s_rw, s_asrc, s_ext, s_fault;
  logic [1:0]  s_pcs, s_rd, s_rds, s_bsrc;
  logic [3:0]  s_alu, s_state;
  logic [3:0]  s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  mc_mips_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Instruction(Instruction), .MemReady(MemReady),
    .Zero(Zero), .AluLsb(AluLsb), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .PCWrite(PCWrite), .PCSource(PCSource), .RegWrite(RegWrite),
    .RegDst(RegDst), .RegDataSel(RegDataSel), .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc),
    .ALUControl(ALUControl), .ExtendSign(ExtendSign), .State(State), .Fault(Fault),
    .RetireCnt(RetireCnt)
  );

  mc_mips_controller #(.MEM_TIMEOUT(16), .CNT_W(4)) dut_small (
    .Clk(Clk), .Reset_n(Reset_n), .Instruction(Instruction), .MemReady(MemReady),
    .Zero(Zero), .AluLsb(AluLsb), .IRWrite(s_irw), .IorD(s_iord), .MemRead(s_mrd),
    .MemWrite(s_mwr), .PCWrite(s_pcw), .PCSource(s_pcs), .RegWrite(s_rw),
    .RegDst(s_rd), .RegDataSel(s_rds), .ALUASrc(s_asrc), .ALUBSrc(s_bsrc),
    .ALUControl(s_alu), .ExtendSign(s_ext), .State(s_state), .Fault(s_fault),
    .RetireCnt(s_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic rdy, input logic z, input logic lsb);
    Instruction = instr;
    MemReady    = rdy;
    Zero        = z;
    AluLsb      = lsb;
    #1;
  endtask

  // FETCH with immediate ready, then DECODE; returns just after the edge leaving DECODE.
  task automatic fetch(input logic [31:0] instr);
    drive(instr, 1'b1, 1'b0, 1'b0);
    check("fetch_state", State, 0);
    check("fetch_irwrite", IRWrite, 1);
    check("fetch_pcwrite", PCWrite, 1);
    check("fetch_memread", MemRead, 1);
    cyc();
    drive(instr, 1'b0, 1'b0, 1'b0);
    check("decode_state", State, 1);
    cyc();
  endtask

  task automatic branch(input string tag, input logic [31:0] instr, input logic z, input logic lsb,
                        input logic [3:0] alu, input logic [1:0] bsrc, input logic taken,
                        input logic [31:0] cnt);
    fetch(instr);
    drive(instr, 1'b0, z, lsb);
    check({tag, "_state"}, State, 8);
    check({tag, "_alu"}, ALUControl, alu);
    check({tag, "_bsrc"}, ALUBSrc, bsrc);
    check({tag, "_pcwrite"}, PCWrite, taken);
    check({tag, "_pcsource"}, PCSource, taken ? 2'd1 : 2'd0);
    check({tag, "_ext"}, ExtendSign, 1);
    cyc();
    check({tag, "_retire"}, RetireCnt, cnt);
  endtask

  initial begin
    Reset_n = 1'b0;
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    #10;
    check("rst_state", State, 0);
    check("rst_memread", MemRead, 0);
    check("rst_fault", Fault, 0);
    check("rst_retire", RetireCnt, 0);
    Reset_n = 1'b1;
    #1;
    check("rel_memread", MemRead, 1);

    // ADD: FETCH, DECODE, EXEC_R, WB
    fetch(I_ADD);
    drive(I_ADD, 1'b0, 1'b0, 1'b0);
    check("add_exec_state", State, 2);
    check("add_exec_alu", ALUControl, 2);
    check("add_exec_bsrc", ALUBSrc, 0);
    check("add_exec_regwrite", RegWrite, 0);
    cyc();
    check("add_wb_state", State, 10);
    check("add_wb_regwrite", RegWrite, 1);
    check("add_wb_regdst", RegDst, 1);
    check("add_wb_datasel", RegDataSel, 0);
    check("add_wb_alu", ALUControl, 2);
    cyc();
    check("add_retire", RetireCnt, 1);
    check("add_retire_small", s_cnt, 1);

    // LW with three not-ready cycles in MEM_RD
    fetch(I_LW);
    drive(I_LW, 1'b0, 1'b0, 1'b0);
    check("lw_addr_state", State, 4);
    check("lw_addr_alu", ALUControl, 2);
    check("lw_addr_bsrc", ALUBSrc, 1);
    check("lw_addr_ext", ExtendSign, 1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("lw_rd_state", State, 5);
      check("lw_rd_memread", MemRead, 1);
      check("lw_rd_iord", IorD, 1);
      cyc();
    end
    drive(I_LW, 1'b1, 1'b0, 1'b0);
    check("lw_rd_ready_state", State, 5);
    cyc();
    drive(I_LW, 1'b0, 1'b0, 1'b0);
    check("lw_wb_state", State, 6);
    check("lw_wb_regwrite", RegWrite, 1);
    check("lw_wb_regdst", RegDst, 0);
    check("lw_wb_datasel", RegDataSel, 1);
    check("lw_wb_memread", MemRead, 0);
    cyc();
    check("lw_retire", RetireCnt, 2);

    // SW
    fetch(I_SW);
    check("sw_addr_state", State, 4);
    cyc();
    drive(I_SW, 1'b1, 1'b0, 1'b0);
    check("sw_wr_state", State, 7);
    check("sw_wr_memwrite", MemWrite, 1);
    check("sw_wr_iord", IorD, 1);
    cyc();
    check("sw_state_after", State, 0);
    check("sw_retire", RetireCnt, 3);

    branch("beq_z1", I_BEQ, 1'b1, 1'b0, 4'd6, 2'd0, 1'b1, 4);
    branch("bne_z1", I_BNE, 1'b1, 1'b0, 4'd6, 2'd0, 1'b0, 5);
    branch("bgez_l0", I_BGEZ, 1'b0, 1'b0, 4'd7, 2'd2, 1'b1, 6);
    branch("bgtz_l0", I_BGTZ, 1'b0, 1'b0, 4'd11, 2'd2, 1'b0, 7);

    // JAL / JR
    fetch(I_JAL);
    check("jal_state", State, 9);
    check("jal_pcwrite", PCWrite, 1);
    check("jal_pcsource", PCSource, 2);
    check("jal_regwrite", RegWrite, 1);
    check("jal_regdst", RegDst, 2);
    check("jal_datasel", RegDataSel, 2);
    cyc();
    check("jal_retire", RetireCnt, 8);
    fetch(I_JR);
    check("jr_state", State, 9);
    check("jr_pcsource", PCSource, 3);
    check("jr_regwrite", RegWrite, 0);
    cyc();
    check("jr_retire", RetireCnt, 9);

    // ADDI through EXEC_I and WB
    fetch(I_ADDI);
    check("addi_exec_state", State, 3);
    check("addi_exec_alu", ALUControl, 2);
    check("addi_exec_bsrc", ALUBSrc, 1);
    check("addi_exec_ext", ExtendSign, 1);
    cyc();
    check("addi_wb_state", State, 10);
    check("addi_wb_regdst", RegDst, 0);
    check("addi_wb_regwrite", RegWrite, 1);
    check("addi_wb_ext", ExtendSign, 1);
    cyc();
    check("addi_retire", RetireCnt, 10);

    // SLL uses rt as A operand and the extended immediate as B
    fetch(I_SLL);
    check("sll_exec_alu", ALUControl, 10);
    check("sll_exec_asrc", ALUASrc, 1);
    check("sll_exec_bsrc", ALUBSrc, 1);
    cyc();
    check("sll_wb_regdst", RegDst, 1);
    cyc();
    check("sll_retire", RetireCnt, 11);

    // Unsupported opcode 6'h3F
    fetch(I_ILL);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    check("ill_state", State, 15);
    check("ill_fault", Fault, 1);
    check("ill_retire", RetireCnt, 11);
`else
    check("ill_state", State, 0);
    check("ill_fault", Fault, 0);
    check("ill_retire", RetireCnt, 12);
`endif
    Reset_n = 1'b0;
    #1;
    check("rst2_state", State, 0);
    check("rst2_retire", RetireCnt, 0);
    Reset_n = 1'b1;
    #1;

    // Ready arriving in the last allowed wait cycle is accepted
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cyc();
    check("wait15_state", State, 0);
    check("wait15_memread", MemRead, 1);
    drive(32'd0, 1'b1, 1'b0, 1'b0);
    check("wait15_irwrite", IRWrite, 1);
    cyc();
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    check("wait15_decode", State, 1);
    cyc();
    check("wait15_retire", RetireCnt, 1);

    // Sixteen not-ready cycles trip the timeout
    for (int i = 0; i < 15; i++) cyc();
    check("to_pre_state", State, 0);
    check("to_pre_fault", Fault, 0);
    cyc();
    check("to_state", State, 15);
    check("to_fault", Fault, 1);
    check("to_memread", MemRead, 0);
    drive(32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc();
    check("to_sticky_state", State, 15);
    check("to_sticky_fault", Fault, 1);
    check("to_sticky_irwrite", IRWrite, 0);
    check("to_frozen_retire", RetireCnt, 1);
    Reset_n = 1'b0;
    #1;
    check("to_rst_state", State, 0);
    check("to_rst_fault", Fault, 0);
    check("to_rst_memread", MemRead, 0);
    Reset_n = 1'b1;
    #1;
    check("to_rel_memread", MemRead, 1);

    // Reset in the middle of a memory read drops the request at once
    fetch(I_LW);
    cyc();
    drive(I_LW, 1'b0, 1'b0, 1'b0);
    check("mid_rd_memread", MemRead, 1);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_memread", MemRead, 0);
    check("mid_rst_iord", IorD, 0);
    check("mid_rst_state", State, 0);
    check("mid_rst_regwrite", RegWrite, 0);
    Reset_n = 1'b1;
    #1;

    // Retire counter wrap on the 4-bit instance
    for (int i = 0; i < 15; i++) fetch(32'd0);
    check("wrap_small_15", s_cnt, 15);
    fetch(32'd0);
    check("wrap_small_0", s_cnt, 0);
    check("wrap_main_16", RetireCnt, 16);
    check("wrap_small_fault", s_fault, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
